// File: rtl/bscan_tap_ctrl.sv
// bscan_tap_ctrl: 1149.1-style TAP controller and instruction decoder driving a bc_3 boundary chain.
// Define BSCAN_TAP_CTRL_IDCODE_EN to add the 32-bit IDCODE register and make IDCODE the default instruction.
module bscan_tap_ctrl #(
  parameter int unsigned IR_WIDTH    = 4,
  parameter int unsigned EXTEST_CODE = 0,
  parameter int unsigned SAMPLE_CODE = 1,
  parameter int unsigned IDCODE_CODE = 2,
  parameter logic [31:0] IDCODE_VAL  = 32'h0000_0001
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tms,
  input  logic       tdi,
  input  logic       chain_so,
  output logic       chain_si,
  output logic       capture_en,
  output logic       shift_dr,
  output logic       update_en,
  output logic       mode,
  output logic       tdo,
  output logic       tdo_en,
  output logic [3:0] tap_state
);

  typedef enum logic [3:0] {
    S_TLR, S_RTI, S_SEL_DR, S_CAP_DR, S_SH_DR, S_EX1_DR, S_PAU_DR, S_EX2_DR,
    S_UPD_DR, S_SEL_IR, S_CAP_IR, S_SH_IR, S_EX1_IR, S_PAU_IR, S_EX2_IR, S_UPD_IR
  } tap_state_e;

`ifdef BSCAN_TAP_CTRL_IDCODE_EN
  localparam bit LP_ID_EN = 1'b1;
`else
  localparam bit LP_ID_EN = 1'b0;
`endif

  localparam logic [IR_WIDTH-1:0] LP_EXTEST     = IR_WIDTH'(EXTEST_CODE);
  localparam logic [IR_WIDTH-1:0] LP_SAMPLE     = IR_WIDTH'(SAMPLE_CODE);
  localparam logic [IR_WIDTH-1:0] LP_IDCODE     = IR_WIDTH'(IDCODE_CODE);
  localparam logic [IR_WIDTH-1:0] LP_IR_CAPTURE = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] LP_IR_DEFAULT = LP_ID_EN ? LP_IDCODE : {IR_WIDTH{1'b1}};

  tap_state_e          r_state;
  tap_state_e          w_next;
  logic [IR_WIDTH-1:0] r_ir;
  logic [IR_WIDTH-1:0] r_ir_shift;
  logic                r_mode;
  logic                r_bypass;
  logic [31:0]         r_id_shift;
  logic                w_sel_chain;
  logic                w_sel_id;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_TLR;
    else     r_state <= w_next;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_TLR:    w_next = tms ? S_TLR    : S_RTI;
      S_RTI:    w_next = tms ? S_SEL_DR : S_RTI;
      S_SEL_DR: w_next = tms ? S_SEL_IR : S_CAP_DR;
      S_CAP_DR: w_next = tms ? S_EX1_DR : S_SH_DR;
      S_SH_DR:  w_next = tms ? S_EX1_DR : S_SH_DR;
      S_EX1_DR: w_next = tms ? S_UPD_DR : S_PAU_DR;
      S_PAU_DR: w_next = tms ? S_EX2_DR : S_PAU_DR;
      S_EX2_DR: w_next = tms ? S_UPD_DR : S_SH_DR;
      S_UPD_DR: w_next = tms ? S_SEL_DR : S_RTI;
      S_SEL_IR: w_next = tms ? S_TLR    : S_CAP_IR;
      S_CAP_IR: w_next = tms ? S_EX1_IR : S_SH_IR;
      S_SH_IR:  w_next = tms ? S_EX1_IR : S_SH_IR;
      S_EX1_IR: w_next = tms ? S_UPD_IR : S_PAU_IR;
      S_PAU_IR: w_next = tms ? S_EX2_IR : S_PAU_IR;
      S_EX2_IR: w_next = tms ? S_UPD_IR : S_SH_IR;
      S_UPD_IR: w_next = tms ? S_SEL_DR : S_RTI;
      default:  w_next = S_TLR;
    endcase
  end

  // NOTE: only control/data registers are reset; there is no memory here to leave uninitialised.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ir       <= LP_IR_DEFAULT;
      r_ir_shift <= '0;
      r_mode     <= (LP_IR_DEFAULT == LP_EXTEST);
    end else begin
      case (r_state)
        S_CAP_IR: r_ir_shift <= LP_IR_CAPTURE;
        S_SH_IR:  r_ir_shift <= {tdi, r_ir_shift[IR_WIDTH-1:1]};
        default:  ;
      endcase
      // Entering Test-Logic-Reset restores the default instruction on the same edge.
      if (w_next == S_TLR) begin
        r_ir   <= LP_IR_DEFAULT;
        r_mode <= (LP_IR_DEFAULT == LP_EXTEST);
      end else if (r_state == S_UPD_IR) begin
        r_ir   <= r_ir_shift;
        r_mode <= (r_ir_shift == LP_EXTEST);
      end
    end
  end

  assign w_sel_chain = (r_ir == LP_EXTEST) || (r_ir == LP_SAMPLE);
  assign w_sel_id    = LP_ID_EN && (r_ir == LP_IDCODE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      r_bypass <= 1'b0;
    else if (r_state == S_CAP_DR) r_bypass <= 1'b0;
    else if (r_state == S_SH_DR)  r_bypass <= tdi;
  end

  // With the feature off w_sel_id is constant 0, so this register never leaves its reset value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id_shift <= IDCODE_VAL;
    end else if (w_sel_id) begin
      if (r_state == S_CAP_DR)     r_id_shift <= IDCODE_VAL;
      else if (r_state == S_SH_DR) r_id_shift <= {tdi, r_id_shift[31:1]};
    end
  end

  always_comb begin
    capture_en = 1'b1;
    shift_dr   = 1'b0;
    update_en  = 1'b0;
    tdo        = 1'b0;
    tdo_en     = 1'b0;
    if (w_sel_chain) begin
      capture_en = (r_state != S_CAP_DR);
      shift_dr   = (r_state == S_SH_DR);
      update_en  = (r_state == S_UPD_DR);
    end
    case (r_state)
      S_SH_IR: begin
        tdo_en = 1'b1;
        tdo    = r_ir_shift[0];
      end
      S_SH_DR: begin
        tdo_en = 1'b1;
        if (w_sel_chain)   tdo = chain_so;
        else if (w_sel_id) tdo = r_id_shift[0];
        else               tdo = r_bypass;
      end
      default: ;
    endcase
  end

  assign chain_si  = tdi;
  assign mode      = r_mode;
  assign tap_state = r_state;

endmodule

// File: tb/tb_bscan_tap_ctrl.sv
// tb_bscan_tap_ctrl: randomized and directed checks of bscan_tap_ctrl against a table-driven TAP model
// plus an 8-cell bc_3 chain model that closes the chain_si -> chain_so loop.
module tb_bscan_tap_ctrl;

  localparam int W   = 4;
  localparam int EXT = 0;
  localparam int SAM = 1;
  localparam int IDC = 2;
  localparam logic [31:0] IDV = 32'h0000_0001;
`ifdef BSCAN_TAP_CTRL_IDCODE_EN
  localparam bit ID_EN = 1'b1;
`else
  localparam bit ID_EN = 1'b0;
`endif
  localparam int DEF_IR = ID_EN ? IDC : (1 << W) - 1;

  logic       clk = 1'b0;
  logic       rst, tms, tdi, chain_so;
  logic       chain_si, capture_en, shift_dr, update_en, mode, tdo, tdo_en;
  logic [3:0] tap_state;

  always #5 clk = ~clk;

  bscan_tap_ctrl #(
    .IR_WIDTH(W), .EXTEST_CODE(EXT), .SAMPLE_CODE(SAM), .IDCODE_CODE(IDC), .IDCODE_VAL(IDV)
  ) dut (
    .clk(clk), .rst(rst), .tms(tms), .tdi(tdi), .chain_so(chain_so),
    .chain_si(chain_si), .capture_en(capture_en), .shift_dr(shift_dr), .update_en(update_en),
    .mode(mode), .tdo(tdo), .tdo_en(tdo_en), .tap_state(tap_state)
  );

  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Next-state tables from the 1149.1 state diagram, indexed by state number (TLR=0 .. UpdIR=15).
  int nxt0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nxt1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  int          m_st, m_ir;
  bit          ir_q[$];
  bit          m_byp;
  logic [31:0] m_id;

  bit [7:0] cells, par_in, upd_latch;
  int       cnt_shift, cnt_upd, cnt_cap;
  logic     obs_tdo;

  function automatic void model_reset();
    m_st = 0;
    m_ir = DEF_IR;
    ir_q.delete();
    for (int i = 0; i < W; i++) ir_q.push_back(1'b0);
    m_byp = 1'b0;
    m_id  = IDV;
  endfunction

  function automatic int ir_value();
    int v = 0;
    for (int i = 0; i < W; i++) v |= int'(ir_q[i]) << i;
    return v;
  endfunction

  task automatic step(input bit t, input bit d);
    bit   sel_chain, sel_id, e_tdo;
    logic o_cap, o_sh, o_up;
    @(negedge clk);
    tms = t;
    tdi = d;
    chain_so = cells[7];
    #1;
    sel_chain = (m_ir == EXT) || (m_ir == SAM);
    sel_id    = ID_EN && (m_ir == IDC);
    if (m_st == 11)     e_tdo = ir_q[0];
    else if (m_st == 4) e_tdo = sel_chain ? cells[7] : (sel_id ? m_id[0] : m_byp);
    else                e_tdo = 1'b0;
    check("tap_state",  tap_state,  m_st);
    check("capture_en", capture_en, !(sel_chain && m_st == 3));
    check("shift_dr",   shift_dr,   sel_chain && m_st == 4);
    check("update_en",  update_en,  sel_chain && m_st == 8);
    check("mode",       mode,       m_ir == EXT);
    check("tdo_en",     tdo_en,     m_st == 4 || m_st == 11);
    check("tdo",        tdo,        e_tdo);
    check("chain_si",   chain_si,   d);
    obs_tdo = tdo;
    o_cap = capture_en;
    o_sh  = shift_dr;
    o_up  = update_en;
    if (o_cap === 1'b0) cnt_cap++;
    if (o_sh === 1'b1)  cnt_shift++;
    if (o_up === 1'b1)  cnt_upd++;
    @(posedge clk);
    if (o_up === 1'b1) upd_latch = cells;
    if (o_cap === 1'b0)     cells = par_in;
    else if (o_sh === 1'b1) cells = {cells[6:0], d};
    case (m_st)
      3: begin
        m_byp = 1'b0;
        if (sel_id) m_id = IDV;
      end
      4: begin
        m_byp = d;
        if (sel_id) m_id = {d, m_id[31:1]};
      end
      10: begin
        ir_q.delete();
        ir_q.push_back(1'b1);
        for (int i = 1; i < W; i++) ir_q.push_back(1'b0);
      end
      11: begin
        void'(ir_q.pop_front());
        ir_q.push_back(d);
      end
      15: m_ir = ir_value();
      default: ;
    endcase
    m_st = t ? nxt1[m_st] : nxt0[m_st];
    if (m_st == 0) m_ir = DEF_IR;
  endtask

  // Both scans start and end in Run-Test/Idle.
  task automatic scan_ir(input int code, output int tdo_bits);
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    tdo_bits = 0;
    for (int i = 0; i < W; i++) begin
      step(i == W - 1, bit'((code >> i) & 1));
      tdo_bits |= int'(obs_tdo) << i;
    end
    step(1, 0); step(0, 0);
  endtask

  task automatic scan_dr(input int n, input logic [63:0] din, output logic [63:0] dout);
    cnt_shift = 0; cnt_upd = 0; cnt_cap = 0;
    dout = '0;
    step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < n; i++) begin
      step(i == n - 1, din[i]);
      dout[i] = obs_tdo;
    end
    step(1, 0); step(0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    tms = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("rst_state",      tap_state,  0);
    check("rst_capture_en", capture_en, 1);
    check("rst_shift_dr",   shift_dr,   0);
    check("rst_update_en",  update_en,  0);
    check("rst_mode",       mode,       0);
    check("rst_tdo",        tdo,        0);
    check("rst_tdo_en",     tdo_en,     0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int          irb, code, n;
    logic [63:0] dout, din;
    bit   [7:0]  latch_before;
    rst = 1'b1; tms = 1'b1; tdi = 1'b0; chain_so = 1'b0;
    cells = '0; par_in = '0; upd_latch = '0;
    model_reset();
    do_reset();

    // Default instruction straight out of reset: IDCODE or single-bit bypass.
    step(0, 0);
    din = 64'h0000_0000_DEAD_BEEF;
    scan_dr(32, din, dout);
    check("default_dr_out", dout[31:0], ID_EN ? IDV : {din[30:0], 1'b0});

    // Five tms=1 cycles from every state.
    for (int s = 0; s < 16; s++) begin
      int guard = 0;
      while (m_st != s && guard < 400) begin
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        guard++;
      end
      #1 check("reach_state", tap_state, s);
      repeat (5) step(1, 1'($urandom_range(0, 1)));
      #1 check("tlr_after_5", tap_state, 0);
    end
    step(0, 0);

    // EXTEST load and an 8-bit chain scan.
    scan_ir(EXT, irb);
    check("ir_capture_tdo", irb, 1);
    #1 check("mode_extest", mode, 1);
    par_in = 8'h1E;
    scan_dr(8, 64'hA5, dout);
    check("chain_tdo",   dout[7:0], 8'h78);
    check("chain_shift", cnt_shift, 8);
    check("chain_cap",   cnt_cap,   1);
    check("chain_upd",   cnt_upd,   1);
    check("chain_latch", upd_latch, 8'hA5);

    // SAMPLE keeps the chain selected with mode=0.
    scan_ir(SAM, irb);
    #1 check("mode_sample", mode, 0);
    par_in = 8'hC3;
    scan_dr(8, 64'h5A, dout);
    check("sample_tdo",   dout[7:0], 8'hC3);
    check("sample_shift", cnt_shift, 8);

    // BYPASS and an unused opcode: one-cycle delay, chain controls idle.
    for (int k = 0; k < 2; k++) begin
      scan_ir(k == 0 ? 15 : 7, irb);
      scan_dr(4, 64'b1101, dout);
      check("bypass_tdo",   dout[3:0], 4'b1010);
      check("bypass_shift", cnt_shift, 0);
      check("bypass_cap",   cnt_cap,   0);
      check("bypass_upd",   cnt_upd,   0);
    end

    // Reset mid-shift with the chain selected: no update may follow.
    scan_ir(EXT, irb);
    par_in = 8'h5A;
    step(1, 0); step(0, 0); step(0, 0); step(0, 1); step(0, 1);
    latch_before = upd_latch;
    do_reset();
    step(1, 0);
    check("rst_no_update", upd_latch, latch_before);
    step(0, 0);

    // Random instructions and scans.
    repeat (40) begin
      case ($urandom_range(0, 5))
        0: code = EXT;
        1: code = SAM;
        2: code = IDC;
        3: code = 15;
        default: code = int'($urandom_range(0, 15));
      endcase
      scan_ir(code, irb);
      check("rand_ir_capture", irb, 1);
      par_in = 8'($urandom);
      n = int'($urandom_range(1, 40));
      din = {$urandom, $urandom};
      scan_dr(n, din, dout);
      repeat ($urandom_range(0, 12)) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat (5) step(1, 0);
      step(0, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/bscan_tap_ctrl.md
Name: bscan_tap_ctrl

Overview:
- IEEE 1149.1-style TAP controller and instruction decoder that drives the control side of a boundary-scan chain built from bc_3-type output cells.
- Generates the cells' capture_en (active-low), shift_dr and mode signals plus an update strobe.
- Routes tdi into the chain and selects tdo from the chain, the bypass bit or the instruction register.
- Sits between the chip JTAG pins and the boundary register.

Parameters:
IR_WIDTH, 4, instruction register width (>=2)
EXTEST_CODE, 0, opcode selecting the chain with mode=1
SAMPLE_CODE, 1, opcode selecting the chain with mode=0
IDCODE_CODE, 2, opcode selecting the ID register (used only with feature)
IDCODE_VAL, 32'h0000_0001, device ID value; bit 0 must be 1

Ports:
clk  input  1  TAP clock (TCK equivalent); all state changes on rising edge
rst  input  1  asynchronous, active-high reset
tms  input  1  test mode select, sampled on rising clk
tdi  input  1  test data in
chain_so  input  1  serial out of the last boundary cell
chain_si  output  1  serial in to the first boundary cell; equals tdi
capture_en  output  1  active-low capture enable to the cells
shift_dr  output  1  shift enable to the cells
update_en  output  1  update strobe for update-capable cells
mode  output  1  cell mode; 1 = drive from the scan path
tdo  output  1  test data out
tdo_en  output  1  tdo output-enable
tap_state  output  4  current TAP state encoding, for debug

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- States: 16-state FSM, encoded 0..15 in standard order: TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauDR, Ex2DR, UpdDR, SelIR, CapIR, ShIR, Ex1IR, PauIR, Ex2IR, UpdIR.
  - Transitions on tms exactly per 1149.1.
  - 5 consecutive tms=1 cycles reach TLR from any state.
- Reset: rst=1 forces the following, asynchronously, in the same cycle:
  - state=TLR
  - active IR = BYPASS (all ones), or IDCODE_CODE when the feature is enabled
  - IR shift register = 0
  - bypass register = 0
  - ID shift register = IDCODE_VAL
  - all outputs: capture_en=1, shift_dr=0, update_en=0, mode=0, tdo=0, tdo_en=0
  - A reset asserted mid-shift discards the partial shift with no update.
- Entering TLR via tms also restores the default active IR.
- IR path:
  - CapIR loads the shift register with {0..., 2'b01}.
  - ShIR shifts right with tdi entering the MSB; tdo = ir_shift[0].
  - UpdIR copies the shift register to the active IR.
- Decode of the active IR:
  - EXTEST_CODE or SAMPLE_CODE selects the chain.
  - IDCODE_CODE selects the ID register (feature only).
  - All ones, and any other code, selects bypass.
- Chain selected (combinational decode of the registered state):
  - capture_en=0 only while state=CapDR.
  - shift_dr=1 only while state=ShDR.
  - update_en=1 only while state=UpdDR.
  - tdo=chain_so while in ShDR.
  - Not selected: capture_en=1, shift_dr=0, update_en=0.
- mode = 1 iff the active IR == EXTEST_CODE; it changes only at UpdIR or reset.
- Bypass:
  - CapDR clears the bit.
  - ShDR loads tdi.
  - tdo = bypass bit in ShDR (1-cycle delay from tdi to tdo).
- tdo_en = 1 iff state is ShIR or ShDR; otherwise tdo=0.
- Simultaneous tms/tdi: tdi is shifted on the same edge as the ShIR/ShDR exit, per standard (the Exit1 transition edge shifts the last bit).

Optional Feature:
- Macro: BSCAN_TAP_CTRL_IDCODE_EN.
- Defined:
  - 32-bit ID register; CapDR loads IDCODE_VAL, ShDR shifts right with tdi entering the MSB, tdo=id_shift[0].
  - Default instruction after reset/TLR is IDCODE_CODE.
- Undefined:
  - No ID register.
  - IDCODE_CODE decodes as bypass.
  - Default instruction is BYPASS.

Test Plan:
- Pulse rst during ShDR with the chain selected -> state=0 (TLR) immediately, shift_dr=0, capture_en=1, mode=0, tdo_en=0.
- From RTI, tms=1 for 5 cycles -> tap_state=0 regardless of the start state; repeat starting from every one of the 16 states.
- Load IR=4'b0000 (EXTEST) via ShIR with 4 tdi bits LSB first -> tdo emits 1,0,0,0 during the shift; mode=1 after UpdIR; next CapDR gives capture_en=0 for exactly 1 cycle.
- EXTEST, shift 8 bits 0xA5 with chain_so looped from a model 8-cell chain -> shift_dr=1 for 8 cycles, chain_si tracks tdi, tdo returns the previous captured pattern; update_en=1 for 1 cycle in UpdDR.
- IR=4'b1111 or unused 4'b0111, ShDR with tdi=1,0,1,1 -> tdo=0,1,0,1 (bypass delay); shift_dr stays 0, capture_en stays 1.
- With BSCAN_TAP_CTRL_IDCODE_EN: after reset, go to ShDR for 32 cycles -> tdo serialises 32'h0000_0001 LSB first; without the macro -> single-bit bypass output starting at 0.
